// File: rtl/misc_unit_n.sv
// Miscellaneous integer unit: BCD adjust, bit reverse, negate, bit scans, decrement
// (2-stage pipeline) and a chunked multi-cycle population count.
module misc_unit_n #(
  parameter int W     = 64,
  parameter int CHUNK = 16
) (
  input  logic           CLK,
  input  logic           RESET,
  input  logic           ACT,
  input  logic [2:0]     OpCODE,
  input  logic [2:0]     SA,
  input  logic [3:0]     DSTi,
  input  logic [W/4-1:0] CIN,
  input  logic [W-1:0]   A,
  output logic           BUSY,
  output logic           RDY,
  output logic           ZERO,
  output logic           SIGN,
  output logic           COUT,
  output logic [2:0]     SR,
  output logic [3:0]     DSTo,
  output logic [W-1:0]   R
);

  localparam int NIB   = W / 4;
  localparam int CNT_W = $clog2(W + 1);
  localparam int IDX_W = 8;

  typedef enum logic [2:0] {
    OP_DAA, OP_DAS, OP_BREV, OP_NEG, OP_POPCNT, OP_BSF, OP_BSR, OP_DEC
  } op_t;

  typedef enum logic [1:0] {IDLE, COUNT, DONE} pop_state_t;

  function automatic int lane_bits(input logic [2:0] sa);
    int l;
    l = 8 << sa;
    return (l > W) ? W : l;
  endfunction

  function automatic logic [W-1:0] lane_mask(input logic [2:0] sa);
    int l;
    l = lane_bits(sa);
    return (l >= W) ? '1 : ((W'(1) << l) - W'(1));
  endfunction

  function automatic logic [CNT_W-1:0] ones(input logic [CHUNK-1:0] x);
    logic [CNT_W-1:0] cnt;
    cnt = '0;
    for (int i = 0; i < CHUNK; i++) cnt = cnt + CNT_W'(x[i]);
    return cnt;
  endfunction

  pop_state_t state, state_nxt;
  logic accept, pop_start, pop_step, pop_finish;

  // A request is only taken while the counter is idle, so results never overtake each other.
  assign accept = ACT & ~BUSY & (state == IDLE);

  // Pipeline stage 1: captured request; stage 2: computed result
  logic           s1_valid, s2_valid;
  op_t            s1_op;
  logic [2:0]     s1_sa, s2_sa;
  logic [3:0]     s1_dst, s2_dst;
  logic [NIB-1:0] s1_cin;
  logic [W-1:0]   s1_a, s2_r;
  logic           s2_zero, s2_sign, s2_cout;

  // POPCNT working registers
  logic [W-1:0]     pop_a;
  logic [2:0]       pop_sa;
  logic [3:0]       pop_dst;
  logic [IDX_W-1:0] chunk_idx, chunk_last;
  logic [CNT_W-1:0] pop_cnt;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
    end else begin
      // NOTE: sequential state always uses non-blocking assignment so every flop samples pre-edge values.
      s1_valid <= accept & (OpCODE != OP_POPCNT);
      s2_valid <= s1_valid;
    end
  end

  // Combinational compute from stage 1
  int             lane_l, top_nib;
  logic [W-1:0]   lane_m, op_a, daa_add, das_sub, rev, bsf_idx, bsr_idx, comp_r;
  logic           daa_c, comp_zero, comp_sign, comp_cout;

  always_comb begin
    lane_l  = lane_bits(s1_sa);
    top_nib = lane_l / 4 - 1;
    lane_m  = lane_mask(s1_sa);
    op_a    = s1_a & lane_m;
  end

  // daa_c ends the loop holding the carry out of the top lane nibble.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    daa_c   = 1'b0;
    daa_add = '0;
    das_sub = '0;
    for (int k = 0; k < NIB; k++) begin
      if (4 * k < lane_l) begin
        daa_c = (op_a[4*k +: 4] > 4'd9) | ((op_a[4*k +: 4] == 4'd9) & daa_c);
        if (s1_cin[k] | daa_c) daa_add = daa_add | (W'(6) << (4 * k));
        if (s1_cin[k])         das_sub = das_sub | (W'(6) << (4 * k));
      end
    end
  end

  always_comb begin
    bsf_idx = '0;
    bsr_idx = '0;
    rev     = '0;
    for (int i = W - 1; i >= 0; i--) if (op_a[i]) bsf_idx = W'(i);
    for (int i = 0; i < W; i++) begin
      if (op_a[i]) bsr_idx = W'(i);
      rev[i] = op_a[W-1-i];
    end
  end

  always_comb begin
    comp_r    = '0;
    comp_cout = 1'b0;
    case (s1_op)
      OP_DAA:    begin comp_r = (op_a + daa_add) & lane_m; comp_cout = daa_c | s1_cin[top_nib]; end
      OP_DAS:    begin comp_r = (op_a - das_sub) & lane_m; comp_cout = s1_cin[top_nib]; end
      OP_BREV:   comp_r = rev >> (W - lane_l);
      OP_NEG:    begin comp_r = (W'(0) - op_a) & lane_m; comp_cout = |op_a; end
      OP_POPCNT: comp_r = '0;
      OP_BSF:    comp_r = bsf_idx;
      OP_BSR:    comp_r = bsr_idx;
      OP_DEC:    begin comp_r = (op_a - W'(1)) & lane_m; comp_cout = ~|op_a; end
    endcase
    comp_zero = (s1_op == OP_BSF || s1_op == OP_BSR) ? ~|op_a : ~|comp_r;
    comp_sign = (s1_op inside {OP_DAA, OP_DAS, OP_BREV, OP_NEG, OP_DEC}) ? comp_r[lane_l-1] : 1'b0;
  end

  // NOTE: datapath registers carry no reset; only the valid bits and FSM state need a known value.
  always_ff @(posedge CLK) begin
    if (accept) begin
      s1_op  <= op_t'(OpCODE);
      s1_sa  <= SA;
      s1_dst <= DSTi;
      s1_cin <= CIN;
      s1_a   <= A;
    end
    if (s1_valid) begin
      s2_r    <= comp_r;
      s2_zero <= comp_zero;
      s2_sign <= comp_sign;
      s2_cout <= comp_cout;
      s2_sa   <= s1_sa;
      s2_dst  <= s1_dst;
    end
    if (pop_start) begin
      pop_a      <= A & lane_mask(SA);
      pop_sa     <= SA;
      pop_dst    <= DSTi;
      chunk_idx  <= '0;
      chunk_last <= IDX_W'((lane_bits(SA) + CHUNK - 1) / CHUNK - 1);
      pop_cnt    <= '0;
    end else if (pop_step) begin
      pop_cnt   <= pop_cnt + ones(pop_a[chunk_idx*CHUNK +: CHUNK]);
      chunk_idx <= chunk_idx + IDX_W'(1);
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept && OpCODE == OP_POPCNT) state_nxt = COUNT;
      COUNT:   if (chunk_idx == chunk_last) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    pop_start  = 1'b0;
    pop_step   = 1'b0;
    pop_finish = 1'b0;
    case (state)
      IDLE:    pop_start  = accept && (OpCODE == OP_POPCNT);
      COUNT:   pop_step   = 1'b1;
      DONE:    pop_finish = 1'b1;
      default: ;
    endcase
  end

  // Result registers hold between RDY pulses; BUSY trails the COUNT state by one edge.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      BUSY <= 1'b0;
      RDY  <= 1'b0;
      ZERO <= 1'b0;
      SIGN <= 1'b0;
      COUT <= 1'b0;
      SR   <= '0;
      DSTo <= '0;
      R    <= '0;
    end else begin
      BUSY <= (state == COUNT);
      RDY  <= 1'b0;
      if (pop_finish) begin
        RDY  <= 1'b1;
        R    <= W'(pop_cnt);
        ZERO <= (pop_cnt == '0);
        SIGN <= 1'b0;
        COUT <= 1'b0;
        SR   <= pop_sa;
        DSTo <= pop_dst;
      end else if (s2_valid) begin
        RDY  <= 1'b1;
        R    <= s2_r;
        ZERO <= s2_zero;
        SIGN <= s2_sign;
        COUT <= s2_cout;
        SR   <= s2_sa;
        DSTo <= s2_dst;
      end
    end
  end

endmodule

// File: tb/tb_misc_unit_n.sv
// Directed bench for misc_unit_n (W=64, CHUNK=16): hand-computed results, latency,
// BUSY window, ignored requests, back-to-back issue and reset abort.
module tb_misc_unit_n;

  localparam int W     = 64;
  localparam int CHUNK = 16;

  localparam logic [2:0] DAA = 3'd0, DAS = 3'd1, BREV = 3'd2, NEG = 3'd3,
                         POPCNT = 3'd4, BSF = 3'd5, BSR = 3'd6, DEC = 3'd7;

  logic           CLK, RESET, ACT;
  logic [2:0]     OpCODE, SA;
  logic [3:0]     DSTi;
  logic [W/4-1:0] CIN;
  logic [W-1:0]   A;
  logic           BUSY, RDY, ZERO, SIGN, COUT;
  logic [2:0]     SR;
  logic [3:0]     DSTo;
  logic [W-1:0]   R;

  int n_tests = 0;
  int n_fail  = 0;

  misc_unit_n #(.W(W), .CHUNK(CHUNK)) dut (
    .CLK(CLK), .RESET(RESET), .ACT(ACT), .OpCODE(OpCODE), .SA(SA), .DSTi(DSTi),
    .CIN(CIN), .A(A), .BUSY(BUSY), .RDY(RDY), .ZERO(ZERO), .SIGN(SIGN), .COUT(COUT),
    .SR(SR), .DSTo(DSTo), .R(R)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [2:0] op, input logic [2:0] sa, input logic [63:0] a,
                      input logic [15:0] cin, input logic [3:0] dst);
    @(negedge CLK);
    ACT = 1'b1; OpCODE = op; SA = sa; A = a; CIN = cin; DSTi = dst;
    @(negedge CLK);
    ACT = 1'b0;
  endtask

  // Called right after send(): counts edges from acceptance to RDY, then checks the result.
  task automatic expect_res(input string tag, input int lat, input logic [63:0] r,
                            input logic [2:0] zsc, input logic [2:0] sr, input logic [3:0] dst);
    int cyc;
    cyc = 0;
    while (RDY !== 1'b1 && cyc < 40) begin
      @(negedge CLK);
      cyc++;
    end
    check({tag, "_lat"}, cyc, lat);
    check({tag, "_r"}, R, r);
    check({tag, "_zsc"}, {ZERO, SIGN, COUT}, zsc);
    check({tag, "_sr_dst"}, {SR, DSTo}, {sr, dst});
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int extra;
    RESET = 1'b1; ACT = 1'b0; OpCODE = '0; SA = '0; DSTi = '0; CIN = '0; A = '0;
    repeat (2) @(negedge CLK);
    check("reset_outputs", {BUSY, RDY, ZERO, SIGN, COUT, SR, DSTo, R}, '0);
    RESET = 1'b0;

    send(DAA, 3'd0, 64'h9A, 16'h0, 4'd1);
    expect_res("daa_9a", 2, 64'h0, 3'b101, 3'd0, 4'd1);

    send(NEG, 3'd1, 64'hABCD_0001, 16'h0, 4'd2);
    expect_res("neg_sa1", 2, 64'hFFFF, 3'b011, 3'd1, 4'd2);
    @(negedge CLK);
    check("rdy_pulse", RDY, 1'b0);
    check("r_hold", R, 64'hFFFF);

    send(DEC, 3'd0, 64'h0, 16'h0, 4'd3);
    expect_res("dec_zero", 2, 64'hFF, 3'b011, 3'd0, 4'd3);

    send(DAA, 3'd1, 64'hFFFF_FFFF_FFFF_0123, 16'h0001, 4'd4);
    expect_res("daa_cin", 2, 64'h0129, 3'b000, 3'd1, 4'd4);

    send(DAS, 3'd1, 64'h1234, 16'h000A, 4'd5);
    expect_res("das_wrap", 2, 64'hB1D4, 3'b011, 3'd1, 4'd5);

    send(BSR, 3'd2, 64'hFFFF_0000_8000_0001, 16'h0, 4'd6);
    expect_res("bsr_sa2", 2, 64'd31, 3'b000, 3'd2, 4'd6);
    send(BSF, 3'd2, 64'hFFFF_0000_8000_0001, 16'h0, 4'd6);
    expect_res("bsf_sa2", 2, 64'd0, 3'b000, 3'd2, 4'd6);
    send(BSR, 3'd2, 64'h0, 16'h0, 4'd6);
    expect_res("bsr_zero", 2, 64'd0, 3'b100, 3'd2, 4'd6);
    send(BSF, 3'd7, 64'h0010_0000, 16'h0, 4'd8);
    expect_res("bsf_sa7", 2, 64'd20, 3'b000, 3'd7, 4'd8);

    // Back-to-back bit reverse
    @(negedge CLK);
    ACT = 1'b1; OpCODE = BREV; SA = 3'd0; A = 64'h01; DSTi = 4'd3; CIN = '0;
    @(negedge CLK);
    A = 64'h80; DSTi = 4'd5;
    @(negedge CLK);
    ACT = 1'b0;
    check("b2b_gap", RDY, 1'b0);
    @(negedge CLK);
    check("b2b_first", {RDY, DSTo, R}, {1'b1, 4'd3, 64'h80});
    @(negedge CLK);
    check("b2b_second", {RDY, DSTo, R}, {1'b1, 4'd5, 64'h01});
    @(negedge CLK);
    check("b2b_end", RDY, 1'b0);

    // Full-width POPCNT; inputs change during COUNT and an ACT in the 2nd BUSY cycle is dropped
    send(POPCNT, 3'd3, '1, 16'h0, 4'd7);
    A = '0; SA = 3'd0;
    @(negedge CLK);
    check("pop_busy1", BUSY, 1'b1);
    @(negedge CLK);
    check("pop_busy2", BUSY, 1'b1);
    ACT = 1'b1; OpCODE = NEG; A = 64'h1; DSTi = 4'd2;
    @(negedge CLK);
    ACT = 1'b0;
    check("pop_busy3", BUSY, 1'b1);
    @(negedge CLK);
    check("pop_busy4", {BUSY, RDY}, 2'b10);
    @(negedge CLK);
    check("pop_done", {BUSY, RDY}, 2'b01);
    check("pop_r", R, 64'd64);
    check("pop_zsc", {ZERO, SIGN, COUT}, 3'b000);
    check("pop_sr_dst", {SR, DSTo}, {3'd3, 4'd7});
    extra = 0;
    repeat (6) begin
      @(negedge CLK);
      if (RDY) extra++;
    end
    check("pop_ignored_act", extra, 0);

    // Lane narrower than one chunk: a single counting cycle
    send(POPCNT, 3'd0, 64'hFF0F, 16'h0, 4'd1);
    expect_res("pop_sa0", 2, 64'd4, 3'b000, 3'd0, 4'd1);

    send(NEG, 3'd0, 64'h0, 16'h0, 4'd2);
    expect_res("neg_zero", 2, 64'd0, 3'b100, 3'd0, 4'd2);

    send(BSR, 3'd7, 64'h8000_0000_0000_0000, 16'h0, 4'd9);
    expect_res("bsr_sa7", 2, 64'd63, 3'b000, 3'd7, 4'd9);

    // Reset in the middle of COUNT
    send(POPCNT, 3'd3, '1, 16'h0, 4'd9);
    @(negedge CLK);
    @(negedge CLK);
    check("rst_pre_busy", BUSY, 1'b1);
    #2 RESET = 1'b1;
    #1 check("rst_async_outputs", {BUSY, RDY, ZERO, SIGN, COUT, SR, DSTo, R}, '0);
    @(negedge CLK);
    RESET = 1'b0;
    check("rst_no_rdy", RDY, 1'b0);
    send(POPCNT, 3'd3, 64'hF0F0_0000_1234_0001, 16'h0, 4'hA);
    expect_res("pop_after_rst", 5, 64'd14, 3'b000, 3'd3, 4'hA);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
